// File: rtl/xc20xx_cfg_pkg.sv
// Shared definitions for the XC20XX slave-serial configuration loader:
// parser state encoding, stream framing constants and a pattern-bit helper.
package xc20xx_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_LEN,
        ST_SYNC,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE,
        ST_ERR
    } cfg_state_e;

    localparam logic [3:0] PREAMBLE  = 4'b0010;
    localparam logic [3:0] SYNC      = 4'b1111;
    localparam int         LEN_W     = 24;
    localparam int         STOP_BITS = 3;

    // Select one bit of a 4-bit framing pattern by its bit position.
    function automatic logic pattern_bit(input logic [3:0] pat, input logic [1:0] idx);
        return pat[idx];
    endfunction

endpackage

// File: rtl/xc20xx_cfg_frame_sr.sv
// Frame shift register with its bit counter. Bits enter at the LSB and move
// toward the MSB, so after WIDTH shifts the first received bit sits at the MSB.
// done is high while the next shift completes the frame, letting the parser
// leave the data phase on the same accepted bit.
module xc20xx_cfg_frame_sr #(
    parameter int WIDTH = 71
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             clear,
    input  logic             din,
    output logic             done,
    output logic [WIDTH-1:0] data
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;

    // Clear before each frame, otherwise shift one accepted data bit in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (clear) begin
            data <= '0;
            cnt  <= '0;
        end else if (shift) begin
            data <= {data[WIDTH-2:0], din};
            cnt  <= cnt + CW'(1);
        end
    end

    assign done = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/xc20xx_cfg_loader.sv
// XC20XX slave-serial configuration loader. Parses idle/preamble/length/sync,
// then assembles NUM_FRAMES frames and strobes each into configuration memory.
// Optional build macro XC20XX_CFG_PARITY_EN: the first stop bit of each frame
// carries even parity over the frame data instead of a fixed 1.
// Handshake: a DIN bit is consumed on a rising K edge only when DIN_VALID is
// high; with DIN_VALID low nothing in the parser moves.
module xc20xx_cfg_loader
    import xc20xx_cfg_pkg::*;
#(
    parameter int FRAME_BITS = 71,
    parameter int NUM_FRAMES = 160,
    parameter int ADDR_W     = 8
) (
    input  logic                  K,
    input  logic                  RST,
    input  logic                  DIN,
    input  logic                  DIN_VALID,
    output logic [FRAME_BITS-1:0] FRAME_DATA,
    output logic [ADDR_W-1:0]     FRAME_ADDR,
    output logic                  FRAME_WE,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int               CNT_W      = 5;
    localparam logic [LEN_W-1:0] LEN_EXPECT = LEN_W'(NUM_FRAMES * (FRAME_BITS + 1 + STOP_BITS));
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_FRAMES - 1);

    cfg_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [LEN_W-1:0] len_sr, len_next, len_shifted;
    logic [ADDR_W-1:0] addr;
    logic             we_q, we_next;
    logic             done_q, err_q;
    logic             sr_shift, sr_clear, sr_done;
    logic             stop_exp;
    logic [FRAME_BITS-1:0] frame_q;

    xc20xx_cfg_frame_sr #(
        .WIDTH(FRAME_BITS)
    ) u_frame_sr (
        .clk  (K),
        .rst  (RST),
        .shift(sr_shift),
        .clear(sr_clear),
        .din  (DIN),
        .done (sr_done),
        .data (frame_q)
    );

    // Expected value of the stop bit currently being received.
    always_comb begin
        stop_exp = 1'b1;
`ifdef XC20XX_CFG_PARITY_EN
        if (cnt == '0) stop_exp = ^frame_q;
`endif
    end

    // State register.
    always_ff @(posedge K or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode; only an accepted bit moves the parser.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        len_next    = len_sr;
        len_shifted = {len_sr[LEN_W-2:0], DIN};
        sr_shift    = 1'b0;
        sr_clear    = 1'b0;
        we_next     = 1'b0;
        if (DIN_VALID) begin
            case (state)
                ST_IDLE: begin
                    if (!DIN) begin
                        state_next = ST_PRE;
                        cnt_next   = '0;
                    end
                end
                ST_PRE: begin
                    // Leading 0 of the preamble was consumed in IDLE.
                    if (DIN != pattern_bit(PREAMBLE, 2'd2 - cnt[1:0])) begin
                        state_next = ST_ERR;
                    end else if (cnt == CNT_W'(2)) begin
                        state_next = ST_LEN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ST_LEN: begin
                    len_next = len_shifted;
                    if (cnt == CNT_W'(LEN_W - 1)) begin
                        cnt_next   = '0;
                        state_next = (len_shifted == LEN_EXPECT) ? ST_SYNC : ST_ERR;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ST_SYNC: begin
                    if (DIN != pattern_bit(SYNC, 2'd3 - cnt[1:0])) begin
                        state_next = ST_ERR;
                    end else if (cnt == CNT_W'(3)) begin
                        state_next = ST_START;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ST_START: begin
                    if (DIN) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                        sr_clear   = 1'b1;
                    end
                end
                ST_DATA: begin
                    sr_shift = 1'b1;
                    if (sr_done) begin
                        state_next = ST_STOP;
                        cnt_next   = '0;
                    end
                end
                ST_STOP: begin
                    if (DIN != stop_exp) begin
                        state_next = ST_ERR;
                    end else if (cnt == CNT_W'(STOP_BITS - 1)) begin
                        we_next    = 1'b1;
                        cnt_next   = '0;
                        state_next = (addr == LAST_ADDR) ? ST_DONE : ST_START;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers, strobe, sticky flags and frame address.
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            len_sr <= '0;
            addr   <= '0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            len_sr <= len_next;
            we_q   <= we_next;
            done_q <= (state_next == ST_DONE);
            err_q  <= (state_next == ST_ERR);
            // Address moves on after the strobe cycle; it parks on the last frame.
            if (we_q && addr != LAST_ADDR) addr <= addr + ADDR_W'(1);
        end
    end

    assign FRAME_DATA = frame_q;
    assign FRAME_ADDR = addr;
    assign FRAME_WE   = we_q;
    assign DONE       = done_q;
    assign ERR        = err_q;

endmodule
